aes_key_round_gen: RTL

AES_KEY_ROUND_GEN -- requirements
Module: aes_key_round_gen

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_key_shedualing.sv | 32 +++
 rtl/aes_key_round_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 round-key generator: sizes, FSM encoding,
// the forward S-box and the GF(2^8) doubling used to advance rcon.
package aes_pkg;

    localparam int          AES_ROUNDS = 10;
    localparam int          KEY_W      = 128;
    localparam logic [7:0]  RCON_INIT  = 8'h01;
    localparam logic [3:0]  LAST_ROUND = 4'(AES_ROUNDS);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_RUN     = 1'b1;

    // Entry x lives at bits [(255-x)*8 +: 8], i.e. row 0 is the most significant word.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_shedualing.sv
// One combinational AES-128 key-expansion step: next round key plus next rcon.
module aes_key_shedualing
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [7:0]       key_rcon_i,
    output logic [KEY_W-1:0] key_next_o,
    output logic [7:0]       key_rcon_o
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] temp_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    // RotWord/SubWord/Rcon on w3, then the chained XOR across the four words
    always_comb begin
        w0_s   = key_i[127:96];
        w1_s   = key_i[95:64];
        w2_s   = key_i[63:32];
        w3_s   = key_i[31:0];
        temp_s = {sbox(w3_s[23:16]), sbox(w3_s[15:8]), sbox(w3_s[7:0]), sbox(w3_s[31:24])}
               ^ {key_rcon_i, 24'h000000};
        n0_s   = w0_s ^ temp_s;
        n1_s   = w1_s ^ n0_s;
        n2_s   = w2_s ^ n1_s;
        n3_s   = w3_s ^ n2_s;
    end

    assign key_next_o = {n0_s, n1_s, n2_s, n3_s};
    assign key_rcon_o = xtime(key_rcon_i);

endmodule

// File: rtl/aes_key_round_gen.sv
// Streams the 11 AES-128 round keys of a loaded cipher key over a valid/ready
// interface, expanding one step per accepted round key.
module aes_key_round_gen
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_v_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             key_ready_o,
    input  logic             flush_i,
    output logic             rk_v_o,
    input  logic             rk_ready_i,
    output logic [KEY_W-1:0] rk_o,
    output logic [3:0]       rk_round_o,
    output logic             rk_last_o
);

    logic [0:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             last_q, last_d;
    logic [KEY_W-1:0] key_step_s;
    logic [7:0]       rcon_step_s;

    aes_key_shedualing u_step (
        .key_i      (key_q),
        .key_rcon_i (rcon_q),
        .key_next_o (key_step_s),
        .key_rcon_o (rcon_step_s)
    );

    // Next-state: flush beats everything; registers only move on load or transfer
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (key_v_i) begin
                key_d   = key_i;
                round_d = 4'd0;
                rcon_d  = RCON_INIT;
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            if (rk_ready_i) begin
                if (round_q == LAST_ROUND) begin
                    state_d = ST_IDLE;
                end else begin
                    key_d   = key_step_s;
                    rcon_d  = rcon_step_s;
                    round_d = round_q + 4'd1;
                end
            end else begin
                state_d = ST_RUN;
            end
        end
        last_d = (state_d == ST_RUN) && (round_d == LAST_ROUND);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
            rcon_q  <= RCON_INIT;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            last_q  <= last_d;
        end
    end

    assign key_ready_o = (state_q == ST_IDLE);
    assign rk_v_o      = (state_q == ST_RUN);
    assign rk_o        = key_q;
    assign rk_round_o  = round_q;
    assign rk_last_o   = last_q;

endmodule
